mul_seq_wide: RTL
=================

Name: mul_seq_wide

Overview:
- Parametrised radix-2^RDX sequential shift-add multiplier; next generation of the team's sequential multiplier.
- Adds a full double-width product, per-operation signed/unsigned mode, a synchronous reset, early termination on leading-zero digits, and an explicit BUSY/DONE handshake.
- Sits as a shared arithmetic unit beside the ALU. A controller starts an operation with START and reads P once DONE is high.

Parameters:
- LEN, 16, operand width in bits; must be a multiple of RDX.
- RDX, 4, bits of B consumed per cycle; DIGIT = LEN/RDX.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  synchronous active-high reset.
- START  input  1  request; sampled only when not BUSY.
- SIGNED  input  1  1 = two's-complement operands, 0 = unsigned; latched with START.
- A  input  LEN  multiplicand; latched with START.
- B  input  LEN  multiplier; latched with START.
- BUSY  output  1  high while in RUN.
- DONE  output  1  high while in DONE; P is valid.
- P  output  2*LEN  product, registered.

Behaviour:
- States: IDLE, RUN, DONE. Reset state: IDLE, with P=0, BUSY=0, DONE=0, and all internal registers cleared.
- RST is synchronous and has priority over everything. RST in any state, including mid-RUN or together with START, puts the block in IDLE with P=0 on that edge. The operation in flight is discarded.
- Accept: START=1 in IDLE or DONE captures the following on that edge:
  - magA = SIGNED&A[LEN-1] ? -A : A, as LEN-bit unsigned, zero-extended to 2*LEN.
  - magB = the same magnitude rule applied to B.
  - neg = SIGNED & (A[LEN-1]^B[LEN-1]).
  - acc = 0.
  - -2^(LEN-1) has magnitude 2^(LEN-1), which is representable unsigned.
- Zero shortcut: if magA==0 or magB==0 at accept, go straight to DONE with P=0 (neg is ignored). DONE is high one cycle after the accept edge.
- Otherwise, go to RUN. On each RUN edge:
  - acc_nx = acc + magA*magB[RDX-1:0], computed mod 2^(2*LEN).
  - magA <<= RDX, within 2*LEN bits.
  - magB >>= RDX.
- RUN exit: when the post-shift magB is 0, go to DONE on the same edge and load P = neg ? -acc_nx : acc_nx (2*LEN two's complement). Otherwise stay in RUN with acc = acc_nx.
- Latency, counted from the accept edge to DONE=1, equals the number of significant RDX-digits of |B|. The range is 1..DIGIT. The zero shortcut takes 1.
- P holds its value in DONE. P is also unchanged in IDLE after reset and during RUN; it keeps the previous result until the new load.
- START is ignored while in RUN: no restart, no state change.
- DONE persists until a new START or RST.
- START in DONE re-accepts on that edge. DONE falls and BUSY rises on the next cycle, unless the zero shortcut applies, in which case DONE stays high and P becomes 0.
- SIGNED=0 gives an unsigned product. The full 2*LEN result never overflows in either mode.
- Inputs A, B and SIGNED are don't-care outside the accept edge.

Test Plan:
- LEN=16, RDX=4, SIGNED=0, A=0xFFFF, B=0xFFFF -> BUSY for 4 cycles, then DONE=1, P=0xFFFE0001.
- SIGNED=1, A=0xFFFD (-3), B=0x0005 -> DONE after 1 cycle, P=0xFFFFFFF1 (-15). With A and B swapped -> P=0xFFFFFFF1, latency 1 (|B|=3).
- SIGNED=1, A=0x8000, B=0x8000 -> P=0x40000000, latency 4. SIGNED=1, A=0x8000, B=0xFFFF -> P=0x00008000, latency 1.
- Zero and early-termination cases:
  - A=0x1234, B=0 -> DONE next cycle, P=0, BUSY never high.
  - A=0x0003, B=0x0100, unsigned -> P=0x00000300, latency 3.
- Start mid-RUN, then reset:
  - A=0xFFFF, B=0xFFFF, with START pulsed again in cycle 2 using A=1, B=1 -> the second START is ignored, P=0xFFFE0001 at cycle 4.
  - Repeat, but assert RST in cycle 2 together with START -> IDLE, P=0, DONE=0, BUSY=0 on the next cycle.
- Back-to-back operations:
  - After DONE with P=0x00000300, START with A=2, B=3 -> DONE drops, and next DONE shows P=0x00000006.
  - Then START with B=0 while in DONE -> DONE stays high, P=0.

Source files
------------

// File: rtl/mul_seq_wide.sv
// mul_seq_wide: radix-2^RDX sequential shift-add multiplier with a full
// 2*LEN-bit product, per-operation signed/unsigned mode, early termination
// once the remaining multiplier digits are all zero, and a BUSY/DONE handshake.
//
// Ports:
//   CLK    in   1        clock, rising edge
//   RST    in   1        synchronous active-high reset, highest priority
//   START  in   1        request; accepted in IDLE or DONE, ignored in RUN
//   SIGNED in   1        1 = two's-complement operands (latched with START)
//   A      in   LEN      multiplicand (latched with START)
//   B      in   LEN      multiplier (latched with START)
//   BUSY   out  1        high while in RUN
//   DONE   out  1        high while in DONE; P is valid
//   P      out  2*LEN    registered product
module mul_seq_wide #(
  parameter int LEN = 16,
  parameter int RDX = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             SIGNED,
  input  logic [LEN-1:0]   A,
  input  logic [LEN-1:0]   B,
  output logic             BUSY,
  output logic             DONE,
  output logic [2*LEN-1:0] P
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [2*LEN-1:0] mag_a_q;
  logic [LEN-1:0]   mag_b_q;
  logic             neg_q;
  logic [2*LEN-1:0] acc_q;
  logic [2*LEN-1:0] p_q;
  logic             busy_q;
  logic             done_q;

  // Operand magnitudes at accept time. -2^(LEN-1) negates to itself, which
  // read as unsigned is exactly its magnitude.
  logic [LEN-1:0]   mag_a_in;
  logic [LEN-1:0]   mag_b_in;
  logic             neg_in;
  logic             zero_in;

  // One RUN step.
  logic [2*LEN-1:0] acc_d;
  logic [2*LEN-1:0] mag_a_d;
  logic [LEN-1:0]   mag_b_d;
  logic [2*LEN-1:0] p_d;

  always_comb begin
    mag_a_in = A;
    mag_b_in = B;
    if (SIGNED && A[LEN-1]) mag_a_in = ~A + {{(LEN-1){1'b0}}, 1'b1};
    if (SIGNED && B[LEN-1]) mag_b_in = ~B + {{(LEN-1){1'b0}}, 1'b1};
    neg_in  = SIGNED & (A[LEN-1] ^ B[LEN-1]);
    zero_in = (mag_a_in == '0) || (mag_b_in == '0);
  end

  always_comb begin
    acc_d   = acc_q + mag_a_q * {{(2*LEN-RDX){1'b0}}, mag_b_q[RDX-1:0]};
    mag_a_d = mag_a_q << RDX;
    mag_b_d = mag_b_q >> RDX;
    p_d     = neg_q ? (~acc_d + {{(2*LEN-1){1'b0}}, 1'b1}) : acc_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      mag_a_q <= '0;
      mag_b_q <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      p_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (START) begin
            mag_a_q <= {{LEN{1'b0}}, mag_a_in};
            mag_b_q <= mag_b_in;
            neg_q   <= neg_in;
            acc_q   <= '0;
            if (zero_in) begin
              // Zero operand: skip RUN entirely, result is 0 regardless of sign.
              state_q <= S_DONE;
              p_q     <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end
        end
        S_RUN: begin
          acc_q   <= acc_d;
          mag_a_q <= mag_a_d;
          mag_b_q <= mag_b_d;
          // Exit as soon as no significant multiplier digits remain.
          if (mag_b_d == '0) begin
            state_q <= S_DONE;
            p_q     <= p_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY = busy_q;
  assign DONE = done_q;
  assign P    = p_q;

endmodule
